// File: rtl/vend_pkg.sv
// Shared key codes, state encodings and key classification for the keypad entry controller.
package vend_pkg;

  localparam logic [3:0] KEY_ENTER = 4'hA;
  localparam logic [3:0] KEY_BACK  = 4'hB;
  localparam logic [3:0] KEY_CLEAR = 4'hC;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ENTRY   = 2'd1,
    ST_PRESENT = 2'd2
  } entry_state_t;

  typedef enum logic {
    DB_RELEASED = 1'b0,
    DB_PRESSED  = 1'b1
  } db_state_t;

  // Keys 0x0-0x9 are product-code digits.
  function automatic logic is_digit(input logic [3:0] key);
    return key <= 4'h9;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Debounces the keypad scanner's pressed flag and key code, emitting one event per press.
module key_debounce
  import vend_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_pressed,
  input  logic [3:0] key_value,
  output logic       key_event,
  output logic [3:0] key_event_value
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

  db_state_t     state;
  logic          armed;
  logic [CW-1:0] cnt;
  logic          sample_pressed;
  logic [3:0]    sample_value;
  logic          stable;
  logic          toward;

  assign stable = (key_pressed == sample_pressed) && (key_value == sample_value);

  // Selects which level counts toward the next transition. Until the first stable
  // release after reset the debouncer stays disarmed, so a key held through reset
  // cannot produce an event.
  always_comb begin
    toward = 1'b0;
    if (state == DB_PRESSED) toward = !key_pressed;
    else if (armed)          toward = key_pressed;
    else                     toward = !key_pressed;
  end

  // Input register, stability counter and press/release FSM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= DB_RELEASED;
      armed           <= 1'b0;
      cnt             <= '0;
      sample_pressed  <= 1'b0;
      sample_value    <= 4'h0;
      key_event       <= 1'b0;
      key_event_value <= 4'h0;
    end else begin
      sample_pressed <= key_pressed;
      sample_value   <= key_value;
      key_event      <= 1'b0;
      if (!stable || !toward) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        cnt <= '0;
        if (state == DB_PRESSED) begin
          state <= DB_RELEASED;
        end else if (!armed) begin
          armed <= 1'b1;
        end else begin
          state           <= DB_PRESSED;
          key_event       <= 1'b1;
          key_event_value <= sample_value;
        end
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/keypad_entry_ctrl.sv
// Keypad entry controller: debounced key events build a BCD product code that is
// presented to the vending FSM over a valid/ack handshake, with an inactivity timeout.
module keypad_entry_ctrl
  import vend_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int MAX_DIGITS      = 2,
  parameter int TIMEOUT_CYCLES  = 5000000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    key_pressed,
  input  logic [3:0]              key_value,
  input  logic                    code_ack,
  output logic                    key_event,
  output logic [3:0]              key_event_value,
  output logic [4*MAX_DIGITS-1:0] code_out,
  output logic [2:0]              digit_count,
  output logic                    code_valid,
  output logic                    entry_error,
  output logic                    timeout
);

  localparam int CODE_W = 4 * MAX_DIGITS;
  localparam int TW     = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  entry_state_t  state;
  logic [TW-1:0] timer;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk            (clk),
    .reset          (reset),
    .key_pressed    (key_pressed),
    .key_value      (key_value),
    .key_event      (key_event),
    .key_event_value(key_event_value)
  );

  // Entry FSM with inactivity timer; ack has priority over a same-cycle key, and a
  // key has priority over a same-cycle timeout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      timer       <= '0;
      code_out    <= '0;
      digit_count <= 3'd0;
      code_valid  <= 1'b0;
      entry_error <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      entry_error <= 1'b0;
      timeout     <= 1'b0;
      if (key_event || state != ST_ENTRY) timer <= '0;
      else                                timer <= timer + 1'b1;

      if (state == ST_PRESENT && code_ack) begin
        state       <= ST_IDLE;
        code_out    <= '0;
        digit_count <= 3'd0;
        code_valid  <= 1'b0;
      end else if (key_event) begin
        if (key_event_value == KEY_CLEAR) begin
          state       <= ST_IDLE;
          code_out    <= '0;
          digit_count <= 3'd0;
          code_valid  <= 1'b0;
        end else if (state == ST_PRESENT) begin
          if (key_event_value <= KEY_BACK) entry_error <= 1'b1;
        end else if (is_digit(key_event_value)) begin
          if (digit_count < 3'(MAX_DIGITS)) begin
            code_out    <= (code_out << 4) | CODE_W'(key_event_value);
            digit_count <= digit_count + 3'd1;
            state       <= ST_ENTRY;
          end else begin
            entry_error <= 1'b1;
          end
        end else if (key_event_value == KEY_ENTER) begin
          if (digit_count == 3'(MAX_DIGITS)) begin
            state      <= ST_PRESENT;
            code_valid <= 1'b1;
          end else begin
            entry_error <= 1'b1;
          end
        end else if (key_event_value == KEY_BACK) begin
          if (digit_count != 3'd0) begin
            code_out    <= code_out >> 4;
            digit_count <= digit_count - 3'd1;
            if (digit_count == 3'd1) state <= ST_IDLE;
          end else begin
            entry_error <= 1'b1;
          end
        end
      end else if (state == ST_ENTRY && timer == TW'(TIMEOUT_CYCLES - 1)) begin
        state       <= ST_IDLE;
        code_out    <= '0;
        digit_count <= 3'd0;
        timeout     <= 1'b1;
      end
    end
  end

endmodule

// File: doc/keypad_entry_ctrl.md
Name: keypad_entry_ctrl

Overview:
- Sequences the 4x4 matrix keypad scanner for the vending machine.
- Debounces the scanner's pressed flag and key code, and emits exactly one event per physical press.
- Assembles a multi-digit BCD product code with enter, backspace and clear editing.
- Presents the finished code to the vending FSM over a valid/ack handshake; an inactivity timeout abandons stale entries.

Parameters:
- DEBOUNCE_CYCLES, 20000: consecutive stable cycles required to accept a press or a release (minimum 2).
- MAX_DIGITS, 2: digits in a complete product code (1..4).
- TIMEOUT_CYCLES, 5000000: idle cycles in ENTRY before the partial code is discarded.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous active-low reset.
- key_pressed, input, 1: scanner flag, 1 while any row line is low.
- key_value, input, 4: scanner key code; valid only while key_pressed=1.
- code_ack, input, 1: vending FSM accepts the presented code.
- key_event, output, 1: one-cycle pulse per accepted press.
- key_event_value, output, 4: code of the accepted key; held until the next event.
- code_out, output, 4*MAX_DIGITS: BCD digits, most recent digit in bits [3:0].
- digit_count, output, 3: digits currently entered.
- code_valid, output, 1: code_out is complete and presented.
- entry_error, output, 1: one-cycle pulse on an illegal key.
- timeout, output, 1: one-cycle pulse when the entry is abandoned.

Behaviour:
- Reset (async, active-low): all outputs 0, state IDLE, debouncer in RELEASED with its counter cleared.
- Input stage: key_pressed and key_value are registered once.
- Debouncer (RELEASED/PRESSED):
  - A sample counts as stable when pressed and value both match the previous registered sample; any mismatch zeroes the counter.
  - RELEASED->PRESSED after DEBOUNCE_CYCLES stable pressed samples.
  - key_event pulses on the cycle the transition is taken. Latency: DEBOUNCE_CYCLES+1 cycles from the first stable input cycle.
  - PRESSED->RELEASED only after DEBOUNCE_CYCLES stable released samples.
  - No auto-repeat. A value change while held does not create a new event.
- Key map: 0x0-0x9 digit; 0xA ENTER; 0xB BACKSPACE; 0xC CLEAR; 0xD-0xF ignored (no error).
- Entry FSM (IDLE, ENTRY, PRESENT). Registers update the cycle after key_event.
  - Digit with count<MAX_DIGITS: code_out = {code_out shifted left 4, digit}, count+1, state ENTRY.
  - Digit with count==MAX_DIGITS: ignored, entry_error pulse.
  - ENTER with count==MAX_DIGITS: state PRESENT, code_valid=1.
  - ENTER with count<MAX_DIGITS: entry_error pulse, no state change.
  - BACKSPACE with count>0: code_out shifted right 4, count-1. Count reaching 0 returns to IDLE.
  - BACKSPACE with count=0: entry_error pulse.
  - CLEAR: code_out=0, count=0, state IDLE, from any state.
- PRESENT:
  - code_valid and code_out stay stable until code_ack.
  - code_ack=1 returns to IDLE with code_out=0, count=0, code_valid deasserted the next cycle.
  - Digit, ENTER and BACKSPACE give an entry_error pulse and are otherwise ignored.
  - CLEAR withdraws the code (code_valid=0).
  - code_ack in the same cycle as a CLEAR update: ack wins, and the clear is a no-op on the already-empty entry.
  - code_ack outside PRESENT is ignored.
- Timeout:
  - The counter runs only in ENTRY and is reset by every key_event.
  - At TIMEOUT_CYCLES: clear the entry, go to IDLE, pulse timeout.
  - A key_event in the same cycle as expiry wins; no timeout fires.
- Reset mid-press: after reset, a key that is still held must be released and pressed again. The debouncer starts in RELEASED and needs stable released samples first, so a held key produces no event.

Decomposition:
- Package vend_pkg:
  - KEY_ENTER=4'hA, KEY_BACK=4'hB, KEY_CLEAR=4'hC.
  - Entry state encoding IDLE/ENTRY/PRESENT.
  - Debouncer state encoding.
- Sub-module key_debounce (parameter DEBOUNCE_CYCLES): input register, stability counter and press/release FSM, producing key_event and key_event_value.
- keypad_entry_ctrl instantiates key_debounce and implements the entry FSM, timeout and handshake.

Test Plan (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=50, MAX_DIGITS=2):
- Bounce: key 0x5 toggles pressed every cycle for 10 cycles, then holds 20 cycles, then releases 10 -> exactly one key_event with value 0x5, pulsing 5 cycles after the hold starts.
- Entry: press 0x1, 0x7, 0xA -> code_out=0x17, digit_count=2, code_valid=1. Hold code_ack=0 for 30 cycles, then assert it -> code_valid=0 and code_out=0x00 the next cycle.
- Editing: press 0x3, 0xB, 0x9, 0x4, then 0x6 -> entry_error pulse on 0x6, final code_out=0x94. Then 0xC -> code_out=0, digit_count=0, state IDLE.
- Early enter: press 0x2, 0xA -> entry_error pulse, code_valid stays 0, code_out=0x02.
- Timeout: press 0x8, then idle 50 cycles -> timeout pulse, code_out=0, digit_count=0. Repeat with a key at cycle 49 -> no timeout pulse.
- Reset: assert reset while 0x4 is held and in PRESENT -> all outputs 0 immediately. Key held through reset release -> no event until it is released and pressed again.
